// File: rtl/memory_sp_param_if.sv
// Request/response bundle for memory_sp_param: the master issues requests
// and the slave (the RAM) returns read data and status strobes.
interface memory_sp_param_if #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ADDR_W = 10
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              par_inj;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              addr_err;
    logic              par_err;

    modport master (
        output wr_en, rd_en, addr, data_in, par_inj,
        input  data_out, rd_valid, busy, addr_err, par_err
    );

    modport slave (
        input  wr_en, rd_en, addr, data_in, par_inj,
        output data_out, rd_valid, busy, addr_err, par_err
    );
endinterface

// File: rtl/memory_sp_param.sv
// Parametrised single-port synchronous RAM with power-up clear sequencer,
// registered read, read-during-write mode and out-of-range flag.
// Optional per-word even parity: define MEMORY_SP_PARITY_EN.
module memory_sp_param #(
    parameter int unsigned       DATA_W  = 14,
    parameter int unsigned       ADDR_W  = 10,
    parameter int unsigned       DEPTH   = 1024,
    parameter int unsigned       RD_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input logic               iclk,
    input logic               irst,
    memory_sp_param_if.slave  bus
);

`ifdef MEMORY_SP_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif
    localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                rd_valid_q, rd_valid_d;
    logic                addr_err_q, addr_err_d;
    logic                par_err_q, par_err_d;

    logic [WORD_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_idx;
    logic [WORD_W-1:0]   mem_wdata;

    logic                in_range;
    logic [IDX_W-1:0]    req_idx;
    logic [WORD_W-1:0]   clr_word;
    logic [WORD_W-1:0]   wr_word;
    logic [WORD_W-1:0]   rd_word;
    logic [WORD_W-1:0]   rd_sel;

`ifndef MEMORY_SP_PARITY_EN
    logic unused_par_inj;
    assign unused_par_inj = bus.par_inj;
`endif

    // Next-state, write port and read-result selection.
    always_comb begin
`ifdef MEMORY_SP_PARITY_EN
        clr_word = {^CLR_VAL, CLR_VAL};
        wr_word  = {(^bus.data_in) ^ bus.par_inj, bus.data_in};
`else
        clr_word = CLR_VAL;
        wr_word  = bus.data_in;
`endif
        in_range   = {1'b0, bus.addr} < DEPTH_A;
        req_idx    = IDX_W'(bus.addr);
        rd_word    = mem_q[req_idx];
        rd_sel     = rd_word;

        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        par_err_d  = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = req_idx;
        mem_wdata  = wr_word;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = IDX_W'(ptr_q);
                mem_wdata = clr_word;
                ptr_d     = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                mem_we     = bus.wr_en & in_range;
                addr_err_d = (bus.wr_en | bus.rd_en) & ~in_range;
                if (bus.rd_en) begin
                    rd_valid_d = 1'b1;
                    if (in_range) begin
                        // Write-first mode forwards the incoming word.
                        if (bus.wr_en && RD_MODE == 1) rd_sel = wr_word;
                        data_out_d = rd_sel[DATA_W-1:0];
`ifdef MEMORY_SP_PARITY_EN
                        par_err_d  = ^rd_sel;
`endif
                    end else begin
                        data_out_d = '0;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
            par_err_q  <= par_err_d;
        end
    end

    // Storage array is not reset; the clear sequencer initialises it.
    always_ff @(posedge iclk) begin
        if (irst && mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
    assign bus.addr_err = addr_err_q;
    assign bus.par_err  = par_err_q;

endmodule
